// File: rtl/neuron_loader_if.sv
// rtl/neuron_loader_if.sv - byte stream in / result out handshakes of the neuron loader
interface neuron_loader_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0]   in_data;
   logic               in_valid;
   logic               in_ready;
   logic [2*WIDTH+1:0] res_data;
   logic               res_valid;
   logic               res_ready;

   modport master (
      output in_data, in_valid, res_ready,
      input  in_ready, res_data, res_valid
   );

   modport slave (
      input  in_data, in_valid, res_ready,
      output in_ready, res_data, res_valid
   );
endinterface

// File: rtl/neuron_loader.sv
// rtl/neuron_loader.sv - assembles x/w/b lanes from a byte stream, captures neuron y one cycle later
module neuron_loader #(
   parameter int N     = 4,
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   neuron_loader_if.slave       bus,
   output logic [N*WIDTH-1:0]   x_out,
   output logic [N*WIDTH-1:0]   w_out,
   output logic [WIDTH-1:0]     b_out,
   input  logic [2*WIDTH+1:0]   y_in,
   output logic                 busy
);
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

   typedef enum logic [2:0] {
      S_LOAD_X,
      S_LOAD_W,
      S_LOAD_B,
      S_EVAL,
      S_OUT
   } state_e;

   state_e               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [N*WIDTH-1:0]   x_q, x_d;
   logic [N*WIDTH-1:0]   w_q, w_d;
   logic [WIDTH-1:0]     b_q, b_d;
   logic [2*WIDTH+1:0]   res_q, res_d;
   logic                 res_valid_q, res_valid_d;
   logic                 load_st;
   logic                 accept;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_LOAD_X;
         cnt_q       <= '0;
         x_q         <= '0;
         w_q         <= '0;
         b_q         <= '0;
         res_q       <= '0;
         res_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         x_q         <= x_d;
         w_q         <= w_d;
         b_q         <= b_d;
         res_q       <= res_d;
         res_valid_q <= res_valid_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      x_d         = x_q;
      w_d         = w_q;
      b_d         = b_q;
      res_d       = res_q;
      res_valid_d = res_valid_q;
      load_st     = (state_q == S_LOAD_X) || (state_q == S_LOAD_W) || (state_q == S_LOAD_B);
      accept      = bus.in_valid && load_st;

      case (state_q)
         S_LOAD_X: begin
            if (accept) begin
               for (int i = 0; i < N; i++) begin
                  if (cnt_q == CW'(i)) x_d[i*WIDTH +: WIDTH] = bus.in_data;
               end
               if (cnt_q == CNT_LAST) begin
                  state_d = S_LOAD_W;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         S_LOAD_W: begin
            if (accept) begin
               for (int i = 0; i < N; i++) begin
                  if (cnt_q == CW'(i)) w_d[i*WIDTH +: WIDTH] = bus.in_data;
               end
               if (cnt_q == CNT_LAST) begin
                  state_d = S_LOAD_B;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         S_LOAD_B: begin
            if (accept) begin
               b_d     = bus.in_data;
               state_d = S_EVAL;
            end
         end
         // lanes are stable through this whole cycle, giving neuron a full period to settle
         S_EVAL: begin
            res_d       = y_in;
            res_valid_d = 1'b1;
            state_d     = S_OUT;
         end
         S_OUT: begin
            if (bus.res_ready) begin
               res_valid_d = 1'b0;
               state_d     = S_LOAD_X;
               cnt_d       = '0;
            end
         end
         default: begin
            state_d = S_LOAD_X;
            cnt_d   = '0;
         end
      endcase
   end

   assign bus.in_ready  = load_st;
   assign bus.res_data  = res_q;
   assign bus.res_valid = res_valid_q;
   assign x_out         = x_q;
   assign w_out         = w_q;
   assign b_out         = b_q;
   assign busy          = !((state_q == S_LOAD_X) && (cnt_q == '0));
endmodule

// File: tb/tb_neuron_loader.sv
// tb/tb_neuron_loader.sv - self-checking bench for neuron_loader with a behavioural neuron and result model
module tb_neuron_loader;
   localparam int N = 4;
   localparam int W = 8;

   logic            clk;
   logic            rst;
   logic [N*W-1:0]  x_out, w_out;
   logic [W-1:0]    b_out;
   logic [2*W+1:0]  y_in;
   logic            busy;

   neuron_loader_if #(.WIDTH(W)) bus ();

   neuron_loader #(.N(N), .WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .bus   (bus),
      .x_out (x_out),
      .w_out (w_out),
      .b_out (b_out),
      .y_in  (y_in),
      .busy  (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // behavioural neuron: y = ReLU(sum x*w + b)
   int nsum;
   always_comb begin
      nsum = int'($signed(b_out));
      for (int i = 0; i < N; i++)
         nsum = nsum + int'($signed(x_out[i*W +: W])) * int'($signed(w_out[i*W +: W]));
      y_in = (nsum < 0) ? '0 : 18'(nsum);
   end

   int errors = 0;
   int checks = 0;
   int frame[9];
   logic [2*W+1:0] got_q[$];
   logic [W-1:0]   acc_q[$];
   int beats_acc = 0;

   always @(negedge clk) begin
      #1;
      if (!rst) begin
         if (bus.in_valid && bus.in_ready) begin
            beats_acc++;
            acc_q.push_back(bus.in_data);
         end
         if (bus.res_valid && bus.res_ready) got_q.push_back(bus.res_data);
      end
   end

   function automatic int ref_y();
      int s;
      s = frame[2*N];
      for (int i = 0; i < N; i++) s += frame[i] * frame[N+i];
      return (s < 0) ? 0 : s;
   endfunction

   task automatic set_frame1();
      frame = '{1, 2, 3, 4, 1, 1, 1, 1, 5};
   endtask

   task automatic set_frame2();
      frame = '{2, 2, 2, 2, -1, -1, -1, -1, -1};
   endtask

   // presents nbeats of frame; returns at the negedge where the last beat is on the bus
   task automatic push_frame(input int nbeats, input int gap);
      for (int i = 0; i < nbeats; i++) begin
         for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
         end
         @(negedge clk);
         bus.in_valid = 1'b1;
         bus.in_data  = 8'(frame[i]);
         begin
            int t = 0;
            while (!bus.in_ready && t < 50) begin
               @(negedge clk);
               t++;
            end
            if (t >= 50) begin
               checks++;
               errors++;
               $display("FAIL push_timeout beat=%0d in_ready=%0b required 1", i, bus.in_ready);
            end
         end
      end
   endtask

   task automatic wait_results(input int target, output bit ok);
      int t = 0;
      while (got_q.size() < target && t < 200) begin
         @(negedge clk);
         t++;
      end
      #2;
      ok = (got_q.size() >= target);
   endtask

   task automatic wait_res_valid(output bit ok);
      int t = 0;
      while (!bus.res_valid && t < 200) begin
         @(negedge clk);
         t++;
      end
      ok = bus.res_valid;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_data = '0;
      bus.res_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b1 || busy !== 1'b0 || bus.res_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl in_ready=%0b busy=%0b res_valid=%0b required 1 0 0", bus.in_ready, busy, bus.res_valid);
      end
      checks++;
      if (x_out !== '0 || w_out !== '0 || b_out !== '0 || bus.res_data !== '0) begin
         errors++;
         $display("FAIL reset_data x=%h w=%h b=%h res=%h required all 0", x_out, w_out, b_out, bus.res_data);
      end
   endtask

   task automatic test_basic();
      bit ok;
      int base = got_q.size();
      bus.res_ready = 1'b1;
      set_frame1();
      push_frame(9, 0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      checks++;
      if (bus.res_valid !== 1'b0 || bus.in_ready !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL basic_eval res_valid=%0b in_ready=%0b busy=%0b required 0 0 1", bus.res_valid, bus.in_ready, busy);
      end
      @(negedge clk);
      checks++;
      if (bus.res_valid !== 1'b1 || bus.res_data !== 18'(ref_y())) begin
         errors++;
         $display("FAIL basic_result res_valid=%0b res_data=%0d required 1 %0d", bus.res_valid, bus.res_data, ref_y());
      end
      checks++;
      if (x_out !== 32'h04030201 || w_out !== 32'h01010101 || b_out !== 8'd5) begin
         errors++;
         $display("FAIL basic_lanes x=%h w=%h b=%h required 04030201 01010101 05", x_out, w_out, b_out);
      end
      @(negedge clk);
      checks++;
      if (bus.res_valid !== 1'b0 || busy !== 1'b0 || bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL basic_pulse res_valid=%0b busy=%0b in_ready=%0b required 0 0 1", bus.res_valid, busy, bus.in_ready);
      end
      wait_results(base + 1, ok);
      checks++;
      if (!ok || got_q[base] !== 18'd15) begin
         errors++;
         $display("FAIL basic_transfer got=%0d ok=%0b required 15", ok ? got_q[base] : 18'd0, ok);
      end
   endtask

   task automatic test_negative();
      bit ok;
      bus.res_ready = 1'b0;
      set_frame2();
      push_frame(9, 0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      wait_res_valid(ok);
      checks++;
      if (!ok || bus.res_data !== 18'(ref_y()) || bus.res_data !== 18'd0) begin
         errors++;
         $display("FAIL relu_clamp res_valid=%0b res_data=%0d required 1 0", bus.res_valid, bus.res_data);
      end
      bus.res_ready = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      bit ok;
      bus.res_ready = 1'b0;
      frame = '{1, 2, -3, 5, 5, 4, 3, 2, 3};
      push_frame(9, 0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      wait_res_valid(ok);
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (!ok || bus.res_valid !== 1'b1 || bus.res_data !== 18'd17 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL hold_cycle%0d res_valid=%0b res_data=%0d in_ready=%0b required 1 17 0", k, bus.res_valid, bus.res_data, bus.in_ready);
         end
         @(negedge clk);
      end
      bus.res_ready = 1'b1;
      checks++;
      if (bus.res_valid !== 1'b1 || bus.res_data !== 18'(ref_y())) begin
         errors++;
         $display("FAIL hold_cycle3 res_valid=%0b res_data=%0d required 1 %0d", bus.res_valid, bus.res_data, ref_y());
      end
      @(negedge clk);
      checks++;
      if (bus.res_valid !== 1'b0 || busy !== 1'b0 || bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL hold_release res_valid=%0b busy=%0b in_ready=%0b required 0 0 1", bus.res_valid, busy, bus.in_ready);
      end
   endtask

   task automatic test_gaps();
      bit ok;
      int base = got_q.size();
      int b0 = beats_acc;
      bus.res_ready = 1'b1;
      frame = '{1, 2, -3, 5, 2, 2, 2, 2, 3};
      push_frame(9, 2);
      @(negedge clk);
      bus.in_valid = 1'b0;
      wait_results(base + 1, ok);
      checks++;
      if (beats_acc - b0 !== 9) begin
         errors++;
         $display("FAIL gap_beats counted=%0d required 9", beats_acc - b0);
      end
      checks++;
      if (!ok || got_q[base] !== 18'd13) begin
         errors++;
         $display("FAIL gap_result got=%0d ok=%0b required 13", ok ? got_q[base] : 18'd0, ok);
      end
   endtask

   task automatic test_mid_reset();
      bit ok;
      int base;
      bus.res_ready = 1'b1;
      set_frame1();
      push_frame(5, 0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (x_out !== '0 || w_out !== '0 || b_out !== '0 || bus.res_data !== '0 || bus.res_valid !== 1'b0
          || busy !== 1'b0 || bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL midreset x=%h w=%h b=%h res=%h rv=%0b busy=%0b rdy=%0b required 0 0 0 0 0 0 1",
                  x_out, w_out, b_out, bus.res_data, bus.res_valid, busy, bus.in_ready);
      end
      rst = 1'b0;
      base = got_q.size();
      push_frame(9, 0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      wait_results(base + 1, ok);
      checks++;
      if (!ok || got_q[base] !== 18'd15) begin
         errors++;
         $display("FAIL midreset_frame got=%0d ok=%0b required 15", ok ? got_q[base] : 18'd0, ok);
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      int base = got_q.size();
      int abase = acc_q.size();
      int b0 = beats_acc;
      logic [W-1:0] exp_beats[$];
      bus.res_ready = 1'b1;
      set_frame1();
      for (int i = 0; i < 9; i++) exp_beats.push_back(8'(frame[i]));
      push_frame(9, 0);
      set_frame2();
      for (int i = 0; i < 9; i++) exp_beats.push_back(8'(frame[i]));
      push_frame(9, 0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      wait_results(base + 2, ok);
      checks++;
      if (!ok || got_q[base] !== 18'd15 || got_q[base+1] !== 18'd0) begin
         errors++;
         $display("FAIL b2b_results ok=%0b first=%0d second=%0d required 15 0", ok,
                  ok ? got_q[base] : 18'd0, ok ? got_q[base+1] : 18'd0);
      end
      checks++;
      if (beats_acc - b0 !== 18) begin
         errors++;
         $display("FAIL b2b_beat_count counted=%0d required 18", beats_acc - b0);
      end
      for (int i = 0; i < 18; i++) begin
         checks++;
         if (acc_q.size() <= abase + i || acc_q[abase+i] !== exp_beats[i]) begin
            errors++;
            $display("FAIL b2b_beat%0d got=%h required %h", i,
                     (acc_q.size() > abase + i) ? acc_q[abase+i] : 8'h00, exp_beats[i]);
         end
      end
   endtask

   task automatic test_random();
      bit ok;
      int exp;
      int base;
      for (int f = 0; f < 8; f++) begin
         for (int i = 0; i < 9; i++) frame[i] = int'($signed(8'($urandom_range(0, 255))));
         exp = ref_y();
         base = got_q.size();
         bus.res_ready = 1'b0;
         push_frame(9, int'($urandom_range(0, 2)));
         @(negedge clk);
         bus.in_valid = 1'b0;
         wait_res_valid(ok);
         repeat ($urandom_range(0, 3)) @(negedge clk);
         bus.res_ready = 1'b1;
         wait_results(base + 1, ok);
         checks++;
         if (!ok || got_q[base] !== 18'(exp)) begin
            errors++;
            $display("FAIL random_frame%0d got=%0d ok=%0b required %0d", f, ok ? got_q[base] : 18'd0, ok, exp);
         end
      end
      bus.res_ready = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL global_timeout sim time exceeded");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_data = '0;
      bus.res_ready = 1'b0;
      test_reset();
      test_basic();
      test_negative();
      test_backpressure();
      test_gaps();
      test_mid_reset();
      test_back_to_back();
      test_random();
      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/neuron_loader.md
# neuron_loader

Sequential front end for the combinational `neuron` block (y = ReLU(Σ xᵢ·wᵢ + b)). It accepts a byte-serial stream of inputs, weights and bias over a valid/ready handshake. It assembles the stream into the packed `x`/`w`/`b` buses that drive `neuron`, samples `neuron`'s `y` after one settle cycle, and returns the result over a second valid/ready handshake. It is the initiator/driver side of `neuron`'s packed-bus interface.

## Interface
- `N`, default 4: number of input/weight lanes.
- `WIDTH`, default 8: signed lane width for x, w and b.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `in_data`  in  WIDTH: stream byte, two's complement.
- `in_valid`  in  1: `in_data` is valid.
- `in_ready`  out  1: the block accepts `in_data`. A beat transfers when `in_valid && in_ready`.
- `x_out`  out  N*WIDTH: packed inputs to `neuron.x`; lane i at bits [i*WIDTH +: WIDTH].
- `w_out`  out  N*WIDTH: packed weights to `neuron.w`, same lane layout as `x_out`.
- `b_out`  out  WIDTH: bias to `neuron.b`.
- `y_in`  in  2*WIDTH+2: `neuron.y`, signed, already ReLU'd.
- `res_data`  out  2*WIDTH+2: captured result.
- `res_valid`  out  1: `res_data` is valid.
- `res_ready`  in  1: the consumer accepts the result. The result transfers when `res_valid && res_ready`.
- `busy`  out  1: high in every state except LOAD_X with beat count 0.

## Operation
- Frame of 2N+1 accepted beats, in this order:
  - x0 … x(N-1);
  - w0 … w(N-1);
  - b.
- Each accepted beat writes its lane register in the same edge. All other lanes hold.
- FSM states:
  - LOAD_X: `in_ready`=1. Beat count `cnt` runs 0..N-1. On the beat with `cnt`=N-1 → LOAD_W, `cnt`←0.
  - LOAD_W: `in_ready`=1. Same counting. On the beat with `cnt`=N-1 → LOAD_B.
  - LOAD_B: `in_ready`=1. On the accepted beat → EVAL.
  - EVAL: `in_ready`=0. Lasts exactly one cycle. At its closing edge `res_data`←`y_in`, `res_valid`←1, → OUT.
  - OUT: `in_ready`=0. `res_data` and `res_valid` are held stable until `res_ready`=1. On that edge `res_valid`←0 → LOAD_X, `cnt`←0.
- `cnt` has width clog2(N), with a minimum of 1 bit. It never wraps past N-1.
- `x_out`, `w_out`, `b_out` retain the previous frame's values until they are overwritten lane by lane. They are never cleared except by reset.
- `in_valid` low in a LOAD state: no state change, `cnt` holds. Gaps of any length are legal.
- `in_valid` high in EVAL/OUT: ignored, because `in_ready`=0. The upstream must hold the beat.
- No arithmetic in this block. `y_in` is captured bit-exact, with no truncation or sign handling.

## Timing
- Reset values:
  - state = LOAD_X, `cnt`=0;
  - `x_out`=0, `w_out`=0, `b_out`=0;
  - `res_data`=0, `res_valid`=0;
  - `in_ready`=1 in the first cycle after reset deasserts (`in_ready` is a combinational function of state);
  - `busy`=0.
- Reset asserted mid-frame or in OUT: everything returns to the reset values on that edge. The pending result is dropped and partial lanes are cleared.
- Latency: with b accepted at edge t, `res_valid`=1 from edge t+1 (the EVAL closing edge). The earliest result transfer is at edge t+2.
- Minimum frame period is 2N+3 cycles: 2N+1 load cycles, EVAL, and one OUT cycle with `res_ready`=1.
- `neuron` is combinational. `x_out`/`w_out`/`b_out` are stable for the full EVAL cycle, so `y_in` has one full cycle to settle.
- `res_ready` high before `res_valid` has no effect. `res_valid` never drops without a transfer, except on reset.

## Test plan
All scenarios instantiate `neuron` with N=4, WIDTH=8 between `x_out`/`w_out`/`b_out` and `y_in`.

1. Reset, then stream 1,2,3,4, 1,1,1,1, 5 back-to-back with `res_ready`=1. Required:
   - `x_out`=0x04030201;
   - `res_data`=15;
   - `res_valid` high for exactly one cycle, 1 cycle after the b beat.
2. Stream 2,2,2,2, 0xFF×4, 0xFF. Required: `res_data`=0 (ReLU of −9), `res_valid`=1.
3. Stream 1,2,0xFD,5, 5,4,3,2, 3, with `res_ready`=0 for 3 cycles after `res_valid` rises. Required:
   - `res_data`=17 held stable;
   - `in_ready`=0 throughout;
   - transfer on the 4th cycle, then LOAD_X with `busy`=0.
4. Toggle `in_valid` (1 cycle on, 2 off) for the frame 1,2,0xFD,5, 2,2,2,2, 3. Required:
   - only the 9 valid beats are counted;
   - `res_data`=13.
5. Assert `rst` after 5 beats. Required:
   - all outputs return to their reset values on the next edge;
   - a following full frame from scenario 1 yields 15.
6. Back-to-back frames 1 and 2 with `in_valid` held high through EVAL/OUT. Required:
   - no beat is lost or duplicated;
   - results 15 then 0.
